ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch stage feeding decode.
// Ports: clk/rst_n; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory side;
//        inst/inst_valid/inst_pc/stall decode side; br_taken/br_target redirect;
//        halt; fetch_count.
// Latency: imem_req one cycle after a consume, inst_valid one cycle after imem_rvalid.
// Backpressure: stall holds a VALID instruction; br_taken overrides stall and flushes.
// Optional macro IFETCH_PERF_CNT_EN enables the saturating delivered-instruction counter;
// without it fetch_count is tied to zero.
module ifetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'hC0E0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic [15:0] inst_pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        halt,
    output logic [15:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    // kill marks the outstanding request as stale (a redirect happened after it was granted).
    logic        kill;
    logic        is_hlt;
    logic        consume;

    assign is_hlt    = (inst[15:14] == 2'b11) && (inst[7:4] == 4'b1111);
    assign consume   = (state == S_VALID) && !br_taken && !stall;
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    assign halt      = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (imem_gnt) state_nxt = S_WAIT;
            S_WAIT: begin
                // Stale or redirected data goes back to REQ for the new pc.
                if (imem_rvalid) state_nxt = (kill || br_taken) ? S_REQ : S_VALID;
            end
            S_VALID: begin
                if (br_taken)    state_nxt = S_REQ;
                else if (!stall) state_nxt = is_hlt ? S_HALT : S_REQ;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            kill       <= 1'b0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            inst_pc    <= 16'h0000;
        end else begin
            case (state)
                S_REQ: begin
                    if (br_taken) begin
                        pc <= br_target;
                        // The granted address is the old pc, so its data must be dropped.
                        if (imem_gnt) kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (br_taken) pc <= br_target;
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (!kill && !br_taken) begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 16'h0001;
                        end
                    end else if (br_taken) begin
                        kill <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (br_taken) pc <= br_target;
                    if (br_taken || !stall) begin
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'h0000;
        end else if (consume && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'h0001;
        end
    end

    assign fetch_count = fetch_cnt_q;
`else
    logic unused_consume;
    assign unused_consume = consume;
    assign fetch_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with address and delivery scoreboards.
// Latency: memory grants on request and answers one cycle after the grant.
// Backpressure: stall/br_taken driven from the stimulus process at the falling edge.
module tb_ifetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_INST = 16'hC0E0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt;
    logic [15:0] fetch_count;

    ifetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_pc(inst_pc),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .halt(halt), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr[$];
    logic [31:0] exp_inst[$];   // {pc, inst}
    logic        gnt_en;
    logic [15:0] halt_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == halt_addr) return 16'hC0F0;
        return {4'h1, a[11:0]};
    endfunction

    // Memory model: grants any request while gnt_en, answers one cycle later.
    initial begin : memory
        logic        pending;
        logic [15:0] paddr;
        pending     = 1'b0;
        paddr       = 16'h0000;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'hDEAD;
        forever begin
            @(negedge clk);
            #1;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 16'hDEAD;
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pending     = 1'b0;
                end
                if (imem_req && gnt_en) begin
                    imem_gnt = 1'b1;
                    pending  = 1'b1;
                    paddr    = imem_addr;
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_req", {16'h0, imem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        chk("req_addr", {16'h0, imem_addr}, {16'h0, exp_addr.pop_front()});
                    end
                end
            end
        end
    end

    // Delivery monitor: each rising inst_valid must match the next expected {pc, inst}.
    initial begin : monitor
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && inst_valid && !prev_v) begin
                if (exp_inst.size() == 0) begin
                    chk("unexpected_inst", {inst_pc, inst}, 32'hFFFF_FFFF);
                end else begin
                    chk("deliver", {inst_pc, inst}, exp_inst.pop_front());
                end
            end
            if (!inst_valid) chk("nop_when_idle", {16'h0, inst}, {16'h0, NOP_INST});
            prev_v = inst_valid;
        end
    end

    // Wait (falling edge) for a valid instruction at pc, then hold it with stall.
    task automatic wait_valid(input logic [15:0] pc);
        int n = 0;
        while (!(inst_valid && inst_pc == pc) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("timeout_valid", 32'h0, {16'h0, pc});
        stall = 1'b1;
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req && n < 60);
        if (n >= 60) chk("timeout_req", 32'h0, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_req"},    {31'h0, imem_req},    32'h0);
        chk({tag, "_imem_addr"},   {16'h0, imem_addr},   {16'h0, RESET_PC});
        chk({tag, "_inst"},        {16'h0, inst},        {16'h0, NOP_INST});
        chk({tag, "_inst_valid"},  {31'h0, inst_valid},  32'h0);
        chk({tag, "_inst_pc"},     {16'h0, inst_pc},     32'h0);
        chk({tag, "_halt"},        {31'h0, halt},        32'h0);
        chk({tag, "_fetch_count"}, {16'h0, fetch_count}, 32'h0);
    endtask

    logic [15:0] exp_cnt6;
    logic [15:0] exp_cnt2;

    initial begin : stimulus
`ifdef IFETCH_PERF_CNT_EN
        exp_cnt6 = 16'd6;
        exp_cnt2 = 16'd2;
`else
        exp_cnt6 = 16'd0;
        exp_cnt2 = 16'd0;
`endif
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 16'h0000;
        gnt_en    = 1'b1;
        halt_addr = 16'h7777;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // Sequential fetch 0,1,2; hold pc 2.
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(16'(i));
            exp_inst.push_back({16'(i), 16'h1000 | 16'(i)});
        end
        rst_n = 1'b1;
        wait_valid(16'h0002);

        // Redirect while VALID drops the held instruction; then stall on 0x1234.
        exp_addr.push_back(16'h0234);
        exp_inst.push_back({16'h0234, 16'h1234});
        br_taken  = 1'b1;
        br_target = 16'h0234;
        @(negedge clk);
        br_taken = 1'b0;
        chk("br_valid_drop", {31'h0, inst_valid}, 32'h0);
        wait_valid(16'h0234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_inst",  {16'h0, inst},    32'h0000_1234);
            chk("stall_pc",    {16'h0, inst_pc}, 32'h0000_0234);
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_noreq", {31'h0, imem_req},   32'h0);
        end

        // Branch in WAIT coinciding with rvalid: 0x235 data dropped, refetch 0x40.
        exp_addr.push_back(16'h0235);
        exp_addr.push_back(16'h0040);
        exp_inst.push_back({16'h0040, 16'h1040});
        stall = 1'b0;
        wait_req();
        @(negedge clk);
        br_taken  = 1'b1;
        br_target = 16'h0040;
        @(negedge clk);
        br_taken = 1'b0;
        chk("br_wait_addr", {16'h0, imem_addr}, 32'h0000_0040);
        wait_valid(16'h0040);

        // Branch in REQ together with grant: 0x41 data killed, refetch 0x80.
        exp_addr.push_back(16'h0041);
        exp_addr.push_back(16'h0080);
        exp_inst.push_back({16'h0080, 16'h1080});
        stall = 1'b0;
        wait_req();
        br_taken  = 1'b1;
        br_target = 16'h0080;
        @(negedge clk);
        br_taken = 1'b0;
        wait_valid(16'h0080);

        // Branch in REQ without grant, to 0xFFFF; pc wraps to 0x0000.
        exp_addr.push_back(16'hFFFF);
        exp_addr.push_back(16'h0000);
        exp_inst.push_back({16'hFFFF, 16'h1FFF});
        exp_inst.push_back({16'h0000, 16'h1000});
        gnt_en = 1'b0;
        stall  = 1'b0;
        wait_req();
        chk("nognt_addr", {16'h0, imem_addr}, 32'h0000_0081);
        br_taken  = 1'b1;
        br_target = 16'hFFFF;
        @(negedge clk);
        br_taken = 1'b0;
        chk("nognt_req_held", {31'h0, imem_req}, 32'h1);
        chk("nognt_new_addr", {16'h0, imem_addr}, 32'h0000_FFFF);
        gnt_en = 1'b1;
        wait_valid(16'h0000);
        @(negedge clk);
        chk("fetch_count_6", {16'h0, fetch_count}, {16'h0, exp_cnt6});

        // Reset pulse while WAIT.
        exp_addr.push_back(16'h0001);
        stall = 1'b0;
        wait_req();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("midwait_reset");

        // Restart and fetch HLT at address 1.
        halt_addr = 16'h0001;
        exp_addr.push_back(16'h0000);
        exp_addr.push_back(16'h0001);
        exp_inst.push_back({16'h0000, 16'h1000});
        exp_inst.push_back({16'h0001, 16'hC0F0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int n = 0;
            while (!halt && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (n >= 60) chk("timeout_halt", 32'h0, 32'h1);
        end
        for (int i = 0; i < 6; i++) begin
            br_taken  = (i % 2 == 0);
            br_target = 16'h0055;
            @(negedge clk);
            chk("halt_flag",     {31'h0, halt},       32'h1);
            chk("halt_noreq",    {31'h0, imem_req},   32'h0);
            chk("halt_novalid",  {31'h0, inst_valid}, 32'h0);
        end
        br_taken = 1'b0;
        chk("fetch_count_halt", {16'h0, fetch_count}, {16'h0, exp_cnt2});
        chk("addr_queue_empty", exp_addr.size(), 32'h0);
        chk("inst_queue_empty", exp_inst.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
